semaforo_n: RTL and testbench

- Parametrised successor to the single-intersection traffic-light controller: drives N_WAYS approaches, each with a red/yellow/green lamp triplet.
- Requests arrive on the per-way `pulso` inputs and are latched.
- Green is granted round-robin, with minimum-green, yellow and all-red clearance times.
- Adds a night flashing-yellow mode and a rest-on-green policy when no other way requests.

---
 rtl/semaforo_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/semaforo_n.sv | 162 ++++++++++++++++
 tb/tb_semaforo_n.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the N-way traffic-light controller.
// Holds the FSM state encoding, lamp triplet codes and the timer-width rule.
package semaforo_pkg;

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  // Per-way lamp triplet {red, yellow, green}
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic lamp_ok(input logic [2:0] l);
    return (l == LAMP_OFF) || (l == LAMP_RED) || (l == LAMP_YEL) || (l == LAMP_GRN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request after i_last, wrapping, i_last itself checked last.
// Purely combinational; o_valid low and o_next = i_last when nothing is requested.
module rr_arbiter
  import semaforo_pkg::*;
#(
  parameter int N_WAYS = 4,
  localparam int AW = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] i_req,
  input  logic [AW-1:0]     i_last,
  output logic [AW-1:0]     o_next,
  output logic              o_valid
);

  always_comb begin
    logic [AW-1:0] w_idx;
    w_idx   = '0;
    o_next  = i_last;
    o_valid = 1'b0;
    for (int k = 1; k <= N_WAYS; k++) begin
      w_idx = AW'((int'(i_last) + k) % N_WAYS);
      if (!o_valid && i_req[w_idx]) begin
        o_next  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_n.sv
// N-way traffic-light controller: latched requests, round-robin green with rest-on-green,
// fixed yellow/all-red clearance, and an immediate night flashing-yellow mode.
module semaforo_n
  import semaforo_pkg::*;
#(
  parameter int N_WAYS      = 4,
  parameter int MIN_GREEN   = 8,
  parameter int YELLOW_CYC  = 3,
  parameter int ALL_RED_CYC = 2,
  parameter int FLASH_CYC   = 5,
  localparam int AW = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_WAYS-1:0] pulso,
  input  logic              night,
  output logic [N_WAYS-1:0] red,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] green,
  output logic [AW-1:0]     active_way,
  output logic [N_WAYS-1:0] req_pending
);

  localparam int TW = timer_w(MIN_GREEN, YELLOW_CYC, ALL_RED_CYC, FLASH_CYC);
  localparam logic [TW-1:0] T_GREEN  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALL_RED_CYC - 1);
  localparam logic [TW-1:0] T_FLASH  = TW'(FLASH_CYC - 1);

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [AW-1:0]     r_way;
  logic [N_WAYS-1:0] r_req;
  logic [N_WAYS-1:0] r_red;
  logic [N_WAYS-1:0] r_yellow;
  logic [N_WAYS-1:0] r_green;

  logic [AW-1:0]     w_arb_next;
  logic              w_arb_vld;
  logic [AW-1:0]     w_grant_way;
  logic [N_WAYS-1:0] w_cur_mask;
  logic [N_WAYS-1:0] w_grant_mask;
  logic [N_WAYS-1:0] w_req_nxt;
  logic              w_timer_done;
  logic              w_enter_flash;
  logic              w_enter_green;
  logic              w_other_req;

  function automatic logic [N_WAYS-1:0] way_mask(input logic [AW-1:0] w);
    logic [N_WAYS-1:0] m;
    m    = '0;
    m[w] = 1'b1;
    return m;
  endfunction

  rr_arbiter #(.N_WAYS(N_WAYS)) u_arb (
    .i_req   (r_req),
    .i_last  (r_way),
    .o_next  (w_arb_next),
    .o_valid (w_arb_vld)
  );

  assign w_timer_done  = (r_timer == '0);
  assign w_enter_flash = night && (r_state != S_FLASH);
  assign w_enter_green = !night && (r_state == S_ALLRED) && w_timer_done;
  assign w_grant_way   = w_arb_vld ? w_arb_next : r_way;
  assign w_cur_mask    = way_mask(r_way);
  assign w_grant_mask  = way_mask(w_grant_way);
  assign w_other_req   = |(r_req & ~w_cur_mask);

  // The granted way's clear is applied after the set so a same-edge pulse cannot survive.
  always_comb begin
    w_req_nxt = r_req | (pulso & ((r_state == S_GREEN) ? ~w_cur_mask : {N_WAYS{1'b1}}));
    if (night || (r_state == S_FLASH))
      w_req_nxt = '0;
    else if (w_enter_green)
      w_req_nxt = w_req_nxt & ~w_grant_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_ALLRED;
      r_timer  <= T_ALLRED;
      r_way    <= '0;
      r_req    <= '0;
      r_red    <= '1;
      r_yellow <= '0;
      r_green  <= '0;
    end else begin
      r_req <= w_req_nxt;
      if (w_enter_flash) begin
        r_state  <= S_FLASH;
        r_timer  <= T_FLASH;
        r_red    <= '0;
        r_yellow <= '1;
        r_green  <= '0;
      end else begin
        case (r_state)
          S_GREEN: begin
            if (!w_timer_done) begin
              r_timer <= r_timer - 1'b1;
            end else if (w_other_req) begin
              r_state  <= S_YELLOW;
              r_timer  <= T_YELLOW;
              r_yellow <= w_cur_mask;
              r_green  <= '0;
            end
          end
          S_YELLOW: begin
            if (!w_timer_done) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_state  <= S_ALLRED;
              r_timer  <= T_ALLRED;
              r_yellow <= '0;
              r_red    <= '1;
            end
          end
          S_ALLRED: begin
            if (!w_timer_done) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_state <= S_GREEN;
              r_timer <= T_GREEN;
              r_way   <= w_grant_way;
              r_green <= w_grant_mask;
              r_red   <= ~w_grant_mask;
            end
          end
          S_FLASH: begin
            if (!night) begin
              r_state  <= S_ALLRED;
              r_timer  <= T_ALLRED;
              r_red    <= '1;
              r_yellow <= '0;
            end else if (!w_timer_done) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_timer  <= T_FLASH;
              r_yellow <= ~r_yellow;
            end
          end
        endcase
      end
    end
  end

  assign red         = r_red;
  assign yellow      = r_yellow;
  assign green       = r_green;
  assign active_way  = r_way;
  assign req_pending = r_req;

  for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_lamp_chk
    a_lamp: assert property (@(posedge clk) disable iff (!reset_n)
      lamp_ok({r_red[gi], r_yellow[gi], r_green[gi]}));
  end

  a_green: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(r_green) && !(|(r_green & r_yellow)));

endmodule

// File: tb/tb_semaforo_n.sv
// Directed bench for semaforo_n with default parameters; lamps checked as {red,yellow,green}.
module tb_semaforo_n;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       night = 1'b0;
  logic [3:0] pulso = 4'b0000;
  logic [3:0] red, yellow, green, req_pending;
  logic [1:0] active_way;
  int errors = 0;
  int checks = 0;

  semaforo_n #(
    .N_WAYS(4), .MIN_GREEN(8), .YELLOW_CYC(3), .ALL_RED_CYC(2), .FLASH_CYC(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pulso(pulso), .night(night),
    .red(red), .yellow(yellow), .green(green),
    .active_way(active_way), .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL rst_lamps got=%b want=%b", {red, yellow, green}, 12'b1111_0000_0000); end
    checks++; if (active_way !== 2'd0) begin errors++; $display("FAIL rst_way got=%0d want=0", active_way); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL rst_req got=%b want=0000", req_pending); end
    @(negedge clk) reset_n = 1'b1;
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL rst_allred1 got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1110_0000_0001) begin errors++; $display("FAIL rst_green0 got=%b want=111000000001", {red, yellow, green}); end
    checks++; if (active_way !== 2'd0) begin errors++; $display("FAIL rst_green0_way got=%0d want=0", active_way); end
  endtask

  task automatic test_single_request;
    step(2);
    pulso = 4'b0100;
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b0100) begin errors++; $display("FAIL single_latch got=%b want=0100", req_pending); end
    step(4);
    checks++; if ({red, yellow, green} !== 12'b1110_0000_0001) begin errors++; $display("FAIL single_green_last got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1110_0001_0000) begin errors++; $display("FAIL single_yellow_first got=%b", {red, yellow, green}); end
    step(2);
    checks++; if ({red, yellow, green} !== 12'b1110_0001_0000) begin errors++; $display("FAIL single_yellow_last got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL single_allred1 got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL single_allred2 got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1011_0000_0100) begin errors++; $display("FAIL single_green2 got=%b want=101100000100", {red, yellow, green}); end
    checks++; if (active_way !== 2'd2) begin errors++; $display("FAIL single_way got=%0d want=2", active_way); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL single_req_clr got=%b want=0000", req_pending); end
  endtask

  task automatic test_rest_on_green;
    step(100);
    checks++; if ({red, yellow, green} !== 12'b1011_0000_0100) begin errors++; $display("FAIL rest_green got=%b", {red, yellow, green}); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL rest_req got=%b want=0000", req_pending); end
  endtask

  task automatic test_back_to_back;
    pulso = 4'b0010;
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b0010) begin errors++; $display("FAIL b2b_latch1 got=%b want=0010", req_pending); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1011_0100_0000) begin errors++; $display("FAIL b2b_yellow2 got=%b", {red, yellow, green}); end
    step(5);
    checks++; if ({red, yellow, green, active_way} !== {12'b1101_0000_0010, 2'd1}) begin errors++; $display("FAIL b2b_green1 got=%b way=%0d", {red, yellow, green}, active_way); end
    pulso = 4'b1001;
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b1001) begin errors++; $display("FAIL b2b_latch_two got=%b want=1001", req_pending); end
    step(12);
    checks++; if ({red, yellow, green, active_way} !== {12'b0111_0000_1000, 2'd3}) begin errors++; $display("FAIL b2b_green3 got=%b way=%0d", {red, yellow, green}, active_way); end
    checks++; if (req_pending !== 4'b0001) begin errors++; $display("FAIL b2b_req_left got=%b want=0001", req_pending); end
    step(13);
    checks++; if ({red, yellow, green, active_way} !== {12'b1110_0000_0001, 2'd0}) begin errors++; $display("FAIL b2b_green0 got=%b way=%0d", {red, yellow, green}, active_way); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL b2b_req_empty got=%b want=0000", req_pending); end
  endtask

  task automatic test_night;
    pulso = 4'b0010;
    step(1);
    pulso = 4'b0000;
    step(7);
    checks++; if ({red, yellow, green} !== 12'b1110_0001_0000) begin errors++; $display("FAIL night_pre_yellow got=%b", {red, yellow, green}); end
    night = 1'b1;
    step(1);
    checks++; if ({red, yellow, green} !== 12'b0000_1111_0000) begin errors++; $display("FAIL night_enter got=%b want=000011110000", {red, yellow, green}); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL night_req_flush got=%b want=0000", req_pending); end
    pulso = 4'b1111;
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL night_pulse_ignored got=%b want=0000", req_pending); end
    step(3);
    checks++; if ({red, yellow, green} !== 12'b0000_1111_0000) begin errors++; $display("FAIL night_on_last got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b0000_0000_0000) begin errors++; $display("FAIL night_off_first got=%b", {red, yellow, green}); end
    step(4);
    checks++; if ({red, yellow, green} !== 12'b0000_0000_0000) begin errors++; $display("FAIL night_off_last got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b0000_1111_0000) begin errors++; $display("FAIL night_on_again got=%b", {red, yellow, green}); end
    night = 1'b0;
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL night_exit_allred1 got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL night_exit_allred2 got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green, active_way} !== {12'b1110_0000_0001, 2'd0}) begin errors++; $display("FAIL night_exit_green got=%b way=%0d", {red, yellow, green}, active_way); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL night_exit_req got=%b want=0000", req_pending); end
  endtask

  task automatic test_grant_entry;
    pulso = 4'b0001;
    step(1);
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL entry_own_way got=%b want=0000", req_pending); end
    pulso = 4'b1000;
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b1000) begin errors++; $display("FAIL entry_latch3 got=%b want=1000", req_pending); end
    step(10);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL entry_allred got=%b", {red, yellow, green}); end
    pulso = 4'b1000;
    step(1);
    checks++; if ({red, yellow, green, active_way} !== {12'b0111_0000_1000, 2'd3}) begin errors++; $display("FAIL entry_green3 got=%b way=%0d", {red, yellow, green}, active_way); end
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL entry_clear_wins got=%b want=0000", req_pending); end
    step(1);
    pulso = 4'b0000;
    checks++; if (req_pending !== 4'b0000) begin errors++; $display("FAIL entry_green_pulse got=%b want=0000", req_pending); end
    step(30);
    checks++; if ({red, yellow, green} !== 12'b0111_0000_1000) begin errors++; $display("FAIL entry_rest got=%b", {red, yellow, green}); end
  endtask

  task automatic test_async_reset;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL arst_lamps got=%b want=111100000000", {red, yellow, green}); end
    checks++; if ({active_way, req_pending} !== 6'b00_0000) begin errors++; $display("FAIL arst_state got way=%0d req=%b", active_way, req_pending); end
    @(negedge clk) reset_n = 1'b1;
    step(1);
    checks++; if ({red, yellow, green} !== 12'b1111_0000_0000) begin errors++; $display("FAIL arst_allred got=%b", {red, yellow, green}); end
    step(1);
    checks++; if ({red, yellow, green, active_way} !== {12'b1110_0000_0001, 2'd0}) begin errors++; $display("FAIL arst_green0 got=%b way=%0d", {red, yellow, green}, active_way); end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_rest_on_green();
    test_back_to_back();
    test_night();
    test_grant_entry();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
